// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg: shared state encoding and default buffer geometry
package capture_ctrl_pkg;
    localparam int ADDR_W_DEF = 10;
    typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READ} state_e;
endpackage

// File: rtl/capture_rd_seq.sv
// capture_rd_seq: walks the circular sample buffer from oldest entry for readout
module capture_rd_seq
    import capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              overflow,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              rd_done
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    assign rd_valid = active_q && !abort;
    assign rd_addr  = addr_q;
    assign rd_last  = active_q && rem_q == (ADDR_W+1)'(1);
    assign rd_done  = rd_valid && rd_ready && rd_last;
    // a wrapped buffer is full, so the oldest sample sits at the write pointer
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            addr_d   = overflow ? wt_addr : '0;
            rem_d    = overflow ? DEPTH : {1'b0, wt_addr};
        end else if (rd_valid && rd_ready) begin
            addr_d   = addr_q + 1'b1;
            rem_d    = rem_q - 1'b1;
            active_d = !rd_last;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
        end
    end
endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: trigger-based sample capture into a circular buffer with readout
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              trig_clk,
    input  logic              trig_rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic              trig_hit,
    input  logic [ADDR_W-1:0] post_len,
    output logic              wt_en,
    output logic [ADDR_W-1:0] wt_addr,
    output logic              overflow_flag,
    output logic              stop_flag,
    output logic [ADDR_W-1:0] stop_addr,
    output logic              busy,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
    logic [ADDR_W-1:0] stop_addr_q, stop_addr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic              ovf_q, ovf_d;
    logic              stop_q, stop_d;
    logic              rd_go, rd_done;
    assign wt_en         = (state_q == ARMED || state_q == POST) && sample_en && !abort;
    assign rd_go         = state_q == DONE && rd_start && !arm && !abort;
    assign busy          = state_q == ARMED || state_q == POST || state_q == READ;
    assign wt_addr       = wt_addr_q;
    assign stop_addr     = stop_addr_q;
    assign overflow_flag = ovf_q;
    assign stop_flag     = stop_q;
    always_comb begin
        state_d     = state_q;
        wt_addr_d   = wt_addr_q;
        stop_addr_d = stop_addr_q;
        post_cnt_d  = post_cnt_q;
        ovf_d       = ovf_q;
        stop_d      = stop_q;
        if (wt_en) begin
            wt_addr_d = wt_addr_q + 1'b1;
            ovf_d     = ovf_q || &wt_addr_q;
        end
        if (abort) begin
            state_d = IDLE;
            stop_d  = 1'b0;
        end else if (arm && (state_q == IDLE || state_q == DONE)) begin
            state_d    = ARMED;
            wt_addr_d  = '0;
            ovf_d      = 1'b0;
            stop_d     = 1'b0;
            post_cnt_d = post_len;
        end else if (rd_go) begin
            state_d = READ;
        end else if (state_q == ARMED && trig_hit && sample_en) begin
            stop_addr_d = wt_addr_q;
            stop_d      = post_cnt_q == '0;
            state_d     = post_cnt_q == '0 ? DONE : POST;
        end else if (state_q == POST && sample_en) begin
            post_cnt_d = post_cnt_q - 1'b1;
            stop_d     = post_cnt_q == ADDR_W'(1);
            state_d    = post_cnt_q == ADDR_W'(1) ? DONE : POST;
        end else if (state_q == READ && rd_done) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge trig_clk) begin
        if (trig_rst) begin
            state_q     <= IDLE;
            wt_addr_q   <= '0;
            stop_addr_q <= '0;
            post_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wt_addr_q   <= wt_addr_d;
            stop_addr_q <= stop_addr_d;
            post_cnt_q  <= post_cnt_d;
            ovf_q       <= ovf_d;
            stop_q      <= stop_d;
        end
    end
    capture_rd_seq #(.ADDR_W(ADDR_W)) u_rd_seq (
        .clk      (trig_clk),
        .rst      (trig_rst),
        .start    (rd_go),
        .abort    (abort),
        .overflow (ovf_q),
        .wt_addr  (wt_addr_q),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rd_last  (rd_last),
        .rd_done  (rd_done)
    );
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed scenarios with write/readout scoreboards for capture_ctrl
module tb_capture_ctrl;
    logic       clk = 1'b0;
    logic       trig_rst = 1'b1;
    logic       arm = 1'b0, abort = 1'b0, sample_en = 1'b0, trig_hit = 1'b0;
    logic [3:0] post_len = '0;
    logic       wt_en, overflow_flag, stop_flag, busy;
    logic [3:0] wt_addr, stop_addr, rd_addr;
    logic       rd_start = 1'b0, rd_ready = 1'b0, rd_valid, rd_last;
    logic [3:0] wq[$];
    logic [4:0] rq[$];
    logic [3:0] m_addr;
    int         n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    capture_ctrl #(.ADDR_W(4)) dut (
        .trig_clk(clk), .trig_rst(trig_rst), .arm(arm), .abort(abort),
        .sample_en(sample_en), .trig_hit(trig_hit), .post_len(post_len),
        .wt_en(wt_en), .wt_addr(wt_addr), .overflow_flag(overflow_flag),
        .stop_flag(stop_flag), .stop_addr(stop_addr), .busy(busy),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_addr(rd_addr), .rd_last(rd_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // inputs are applied at the falling edge; outputs checked 1 time unit later
    task automatic cyc();
        #1;
        if (wt_en) begin
            if (wq.size() == 0) chk("wt_unexpected", wt_en, 0);
            else chk("wt_addr", wt_addr, wq.pop_front());
        end
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) chk("rd_unexpected", rd_valid, 0);
            else chk("rd_beat", {rd_last, rd_addr}, rq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic arm_it(input logic [3:0] len);
        arm = 1'b1; post_len = len; m_addr = '0;
        cyc();
        arm = 1'b0;
        chk("armed_busy", {busy, stop_flag, overflow_flag, wt_addr}, 7'b1000000);
    endtask

    task automatic wr(input logic th);
        sample_en = 1'b1; trig_hit = th;
        wq.push_back(m_addr); m_addr++;
        cyc();
        sample_en = 1'b0; trig_hit = 1'b0;
    endtask

    task automatic read_all(input int n, input logic [3:0] start, input int stall_at);
        int t = 0;
        logic [3:0] a = start;
        for (int i = 0; i < n; i++) begin
            rq.push_back({i == n - 1, a});
            a++;
        end
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0; rd_ready = 1'b1;
        while (busy && t < 200) begin
            if (stall_at >= 0 && n - rq.size() == stall_at) begin
                rd_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    cyc();
                    chk("rd_hold", {rd_valid, rd_addr}, {1'b1, 4'(start + 4'(stall_at))});
                end
                rd_ready = 1'b1;
                stall_at = -1;
            end
            cyc();
            t++;
        end
        rd_ready = 1'b0;
        chk("rd_timeout", t < 200, 1);
        chk("rd_drain", rq.size(), 0);
        chk("rd_idle", {busy, rd_valid, stop_flag}, 3'b001);
    endtask

    initial begin
        @(negedge clk);
        cyc();
        chk("reset", {wt_en, overflow_flag, stop_flag, busy, rd_valid, rd_last, wt_addr, stop_addr, rd_addr}, 0);
        trig_rst = 1'b0;
        // basic capture: trigger at address 4, three post samples
        arm_it(4'd3);
        for (int i = 0; i < 8; i++) wr(i == 4);
        chk("s1_flags", {busy, stop_flag, overflow_flag, stop_addr, wt_addr}, {3'b010, 4'd4, 4'd8});
        sample_en = 1'b1; cyc(); sample_en = 1'b0;
        chk("s1_wdrain", wq.size(), 0);
        read_all(8, 4'd0, -1);
        chk("s1_keep", {stop_addr, overflow_flag}, {4'd4, 1'b0});
        // wrapped capture: trigger on 20th sample, five post samples
        arm_it(4'd5);
        for (int i = 0; i < 25; i++) wr(i == 19);
        chk("s2_flags", {busy, stop_flag, overflow_flag, stop_addr, wt_addr}, {3'b011, 4'd3, 4'd9});
        read_all(16, 4'd9, -1);
        chk("s2_keep", {stop_addr, overflow_flag}, {4'd3, 1'b1});
        // zero post length
        arm_it(4'd0);
        wr(0); wr(0); wr(1);
        chk("s3_flags", {busy, stop_flag, stop_addr, wt_addr}, {2'b01, 4'd2, 4'd3});
        read_all(3, 4'd0, -1);
        // unqualified trigger, post gaps, stray rd_start, readout stall
        arm_it(4'd2);
        wr(0);
        trig_hit = 1'b1; rd_start = 1'b1; cyc(); trig_hit = 1'b0; rd_start = 1'b0;
        chk("s4_ignored", {busy, stop_flag, rd_valid}, 3'b100);
        wr(1);
        cyc(); cyc();
        chk("s4_gap", {busy, stop_flag}, 2'b10);
        wr(0); cyc(); wr(0);
        chk("s4_flags", {busy, stop_flag, stop_addr, wt_addr}, {2'b01, 4'd1, 4'd4});
        read_all(4, 4'd0, 2);
        // abort mid-POST, then arm and abort together
        arm_it(4'd4);
        wr(1); wr(0);
        abort = 1'b1; sample_en = 1'b1;
        #1 chk("s5_abort_wten", wt_en, 0);
        cyc();
        abort = 1'b0; sample_en = 1'b0;
        chk("s5_after", {busy, stop_flag}, 2'b00);
        sample_en = 1'b1; cyc(); sample_en = 1'b0;
        arm = 1'b1; abort = 1'b1; cyc(); arm = 1'b0; abort = 1'b0;
        chk("s5_arm_abort", busy, 0);
        sample_en = 1'b1; cyc(); sample_en = 1'b0;
        chk("s5_wdrain", wq.size(), 0);
        // reset mid-READ, then a fresh capture
        arm_it(4'd1);
        wr(0); wr(1); wr(0);
        rq.push_back({1'b0, 4'd0}); rq.push_back({1'b0, 4'd1});
        rd_start = 1'b1; cyc(); rd_start = 1'b0;
        rd_ready = 1'b1; cyc(); cyc(); rd_ready = 1'b0;
        trig_rst = 1'b1; cyc(); trig_rst = 1'b0;
        chk("s6_reset", {wt_en, overflow_flag, stop_flag, busy, rd_valid, rd_last, wt_addr, stop_addr, rd_addr}, 0);
        chk("s6_rdrain", rq.size(), 0);
        arm_it(4'd1);
        wr(0); wr(0); wr(1); wr(0);
        chk("s6_flags", {busy, stop_flag, stop_addr, wt_addr}, {2'b01, 4'd2, 4'd4});
        read_all(4, 4'd0, -1);
        chk("final_wdrain", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the sample-buffer address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have port trig_clk  in  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port trig_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port arm  in  1  single-cycle request to start a capture.
REQ-005 SHALL have port abort  in  1  cancels any activity.
REQ-006 SHALL have port sample_en  in  1  sample qualifier; one buffer write per qualified cycle.
REQ-007 SHALL have port trig_hit  in  1  trigger condition from trigger_node logic.
REQ-008 SHALL have port post_len  in  ADDR_W  number of post-trigger samples, latched on accepted arm.
REQ-009 SHALL have port wt_en  out  1  buffer write strobe.
REQ-010 SHALL have port wt_addr  out  ADDR_W  buffer write address.
REQ-011 SHALL have port overflow_flag  out  1  write pointer wrapped since arm.
REQ-012 SHALL have port stop_flag  out  1  capture complete.
REQ-013 SHALL have port stop_addr  out  ADDR_W  address of the trigger sample.
REQ-014 SHALL have port busy  out  1  state is ARMED, POST or READ.
REQ-015 SHALL have port rd_start  in  1  request buffer readout.
REQ-016 SHALL have port rd_ready  in  1  consumer ready.
REQ-017 SHALL have port rd_valid  out  1  rd_addr valid.
REQ-018 SHALL have port rd_addr  out  ADDR_W  readout address.
REQ-019 SHALL have port rd_last  out  1  final readout beat.

Function
REQ-020 SHALL implement the FSM states IDLE, ARMED, POST, DONE and READ with registered state.
REQ-021 SHALL accept arm only in IDLE or DONE; on acceptance: ARMED, wt_addr=0, overflow_flag=0, stop_flag=0, post_len latched; the arm cycle itself writes nothing.
REQ-022 SHALL drive wt_en = sample_en combinationally while in ARMED or POST and abort is low, and 0 in all other cases.
REQ-023 SHALL increment wt_addr after every write, wrapping DEPTH-1 -> 0 and setting overflow_flag (sticky) on the wrap.
REQ-024 SHALL, in ARMED with trig_hit&&sample_en, capture stop_addr=wt_addr and go to POST, or to DONE if the latched post_len==0; trig_hit without sample_en is ignored.
REQ-025 SHALL, in POST, decrement the post counter once per write and enter DONE on the write that takes the counter to 0; trigger plus post_len samples are written in total (max DEPTH, so the trigger sample is never overwritten).
REQ-026 SHALL, in DONE, hold stop_flag=1, and go to READ on rd_start (if arm and rd_start are both high, arm wins).
REQ-027 SHALL, in READ, start at oldest = overflow_flag ? wt_addr : 0 with count = overflow_flag ? DEPTH : wt_addr.
REQ-028 SHALL, in READ, hold rd_valid=1 and advance rd_addr (with wrap) only when rd_valid&&rd_ready, holding rd_addr otherwise.
REQ-029 SHALL assert rd_last on the final beat and go to IDLE after its transfer.
REQ-030 SHALL keep stop_flag, stop_addr and overflow_flag unchanged after readout until the next arm.
REQ-031 SHALL, on abort, go to IDLE in the next cycle from any state, clear stop_flag and deassert wt_en and rd_valid in the abort cycle; abort has priority over arm, trig_hit and rd_start.
REQ-032 SHALL ignore rd_start outside DONE and ignore trig_hit outside ARMED.

Reset
REQ-033 SHALL, on trig_rst, enter IDLE and zero wt_addr, stop_addr, overflow_flag, stop_flag, rd_addr and all counters, with busy, rd_valid, rd_last and wt_en at 0 in the next cycle, from any state including mid-POST or mid-READ.

Structure
REQ-034 SHALL place the state enum and the default ADDR_W in package capture_ctrl_pkg.
REQ-035 SHALL implement readout (oldest/count/beat/rd_last) in sub-module capture_rd_seq.

Verification (ADDR_W=4, DEPTH=16)
REQ-036 SHALL cover: sample_en=1, post_len=3, trig_hit at addr 4 -> stop_addr=4, writes 0..7, overflow_flag=0; readout 8 beats addr 0..7, rd_last at 7.
REQ-037 SHALL cover: trig_hit at 20th sample (addr 3), post_len=5 -> overflow_flag=1, last write addr 8; readout 16 beats 9..15,0..8.
REQ-038 SHALL cover: post_len=0, trig_hit at addr 2 -> DONE after that write, stop_addr=2, readout 3 beats.
REQ-039 SHALL cover: trig_hit while sample_en=0 ignored; sample_en gaps in POST stall the post count; rd_ready low for 3 cycles holds rd_addr.
REQ-040 SHALL cover: abort mid-POST -> wt_en=0 same cycle, IDLE next, stop_flag=0; arm+abort together -> stays IDLE.
REQ-041 SHALL cover: trig_rst mid-READ -> all outputs 0 next cycle; new arm then captures normally.
